// File: rtl/lookup_engine_tcam.sv
// Ternary match-table stage lookup: DEPTH key/mask entries with lowest-index priority,
// a three-stage pipeline carrying the PHV, a default action on miss, and saturating hit/miss counters.
module lookup_engine_tcam #(
   parameter int STAGE   = 0,
   parameter int PHV_LEN = 1124,
   parameter int KEY_LEN = 197,
   parameter int ACT_LEN = 625,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KEY_LEN-1:0] extract_key,
   input  logic               key_valid,
   input  logic [PHV_LEN-1:0] phv_in,
   output logic [ACT_LEN-1:0] action,
   output logic               action_valid,
   output logic [PHV_LEN-1:0] phv_out,
   output logic               hit,
   output logic [ADDR_W-1:0]  hit_addr,
   input  logic               cfg_wr_en,
   input  logic [ADDR_W-1:0]  cfg_addr,
   input  logic [KEY_LEN-1:0] cfg_key,
   input  logic [KEY_LEN-1:0] cfg_mask,
   input  logic               cfg_entry_vld,
   input  logic [ACT_LEN-1:0] cfg_action,
   input  logic               cfg_dflt_wr,
   output logic [31:0]        hit_cnt,
   output logic [31:0]        miss_cnt
);

   if (DEPTH < 2 || DEPTH > 64 || ADDR_W != $clog2(DEPTH) || STAGE < 0) begin : g_param_chk
      $error("lookup_engine_tcam: DEPTH must be 2..64 and ADDR_W must equal clog2(DEPTH)");
   end

   // Handshake: key_valid is a one-cycle strobe with no ready; every strobe yields exactly one
   // action_valid strobe three cycles later, in issue order, and nothing can stall the pipe.

   logic [DEPTH-1:0][KEY_LEN-1:0] tbl_key_q, tbl_key_d;
   logic [DEPTH-1:0][KEY_LEN-1:0] tbl_mask_q, tbl_mask_d;
   logic [DEPTH-1:0]              tbl_vld_q, tbl_vld_d;
   logic [DEPTH-1:0][ACT_LEN-1:0] tbl_act_q, tbl_act_d;
   logic [ACT_LEN-1:0]            dflt_act_q, dflt_act_d;

   logic [KEY_LEN-1:0] s1_key_q, s1_key_d;
   logic [PHV_LEN-1:0] s1_phv_q, s1_phv_d;
   logic               s1_vld_q, s1_vld_d;
   logic [DEPTH-1:0]   s2_match_q, s2_match_d;
   logic [PHV_LEN-1:0] s2_phv_q, s2_phv_d;
   logic               s2_vld_q, s2_vld_d;

   logic [ACT_LEN-1:0] action_q, action_d;
   logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
   logic               hit_q, hit_d;
   logic [ADDR_W-1:0]  hit_addr_q, hit_addr_d;
   logic               action_valid_q, action_valid_d;
   logic [31:0]        hit_cnt_q, hit_cnt_d;
   logic [31:0]        miss_cnt_q, miss_cnt_d;

   logic               win_hit;
   logic [ADDR_W-1:0]  win_idx;
   logic [ACT_LEN-1:0] win_act;

   // An out-of-range cfg_addr matches no index, so such writes fall through untouched.
   always_comb begin
      tbl_key_d  = tbl_key_q;
      tbl_mask_d = tbl_mask_q;
      tbl_vld_d  = tbl_vld_q;
      tbl_act_d  = tbl_act_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (cfg_wr_en && cfg_addr == ADDR_W'(i)) begin
            tbl_key_d[i]  = cfg_key;
            tbl_mask_d[i] = cfg_mask;
            tbl_vld_d[i]  = cfg_entry_vld;
            tbl_act_d[i]  = cfg_action;
         end
      end
      dflt_act_d = cfg_dflt_wr ? cfg_action : dflt_act_q;
   end

   always_comb begin
      s1_key_d = extract_key;
      s1_phv_d = phv_in;
      s1_vld_d = key_valid;
      s2_phv_d = s1_phv_q;
      s2_vld_d = s1_vld_q;
      for (int i = 0; i < DEPTH; i++) begin
         s2_match_d[i] = tbl_vld_q[i] & ~(|((s1_key_q ^ tbl_key_q[i]) & tbl_mask_q[i]));
      end
   end

   // The action is read from the live table in S3, so a write landing during S2 is visible here.
   always_comb begin
      win_hit = 1'b0;
      win_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (s2_match_q[i]) begin
            win_hit = 1'b1;
            win_idx = ADDR_W'(i);
         end
      end
      win_act = win_hit ? tbl_act_q[win_idx] : dflt_act_q;
   end

   always_comb begin
      action_valid_d = s2_vld_q;
      action_d       = s2_vld_q ? win_act  : action_q;
      phv_out_d      = s2_vld_q ? s2_phv_q : phv_out_q;
      hit_d          = s2_vld_q ? win_hit  : hit_q;
      hit_addr_d     = s2_vld_q ? win_idx  : hit_addr_q;
      hit_cnt_d      = (s2_vld_q && win_hit && hit_cnt_q != '1) ? hit_cnt_q + 32'd1 : hit_cnt_q;
      miss_cnt_d     = (s2_vld_q && !win_hit && miss_cnt_q != '1) ? miss_cnt_q + 32'd1 : miss_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl_key_q      <= '0;
         tbl_mask_q     <= '0;
         tbl_vld_q      <= '0;
         tbl_act_q      <= '0;
         dflt_act_q     <= '0;
         s1_key_q       <= '0;
         s1_phv_q       <= '0;
         s1_vld_q       <= 1'b0;
         s2_match_q     <= '0;
         s2_phv_q       <= '0;
         s2_vld_q       <= 1'b0;
         action_q       <= '0;
         phv_out_q      <= '0;
         hit_q          <= 1'b0;
         hit_addr_q     <= '0;
         action_valid_q <= 1'b0;
         hit_cnt_q      <= '0;
         miss_cnt_q     <= '0;
      end else begin
         tbl_key_q      <= tbl_key_d;
         tbl_mask_q     <= tbl_mask_d;
         tbl_vld_q      <= tbl_vld_d;
         tbl_act_q      <= tbl_act_d;
         dflt_act_q     <= dflt_act_d;
         s1_key_q       <= s1_key_d;
         s1_phv_q       <= s1_phv_d;
         s1_vld_q       <= s1_vld_d;
         s2_match_q     <= s2_match_d;
         s2_phv_q       <= s2_phv_d;
         s2_vld_q       <= s2_vld_d;
         action_q       <= action_d;
         phv_out_q      <= phv_out_d;
         hit_q          <= hit_d;
         hit_addr_q     <= hit_addr_d;
         action_valid_q <= action_valid_d;
         hit_cnt_q      <= hit_cnt_d;
         miss_cnt_q     <= miss_cnt_d;
      end
   end

   assign action       = action_q;
   assign action_valid = action_valid_q;
   assign phv_out      = phv_out_q;
   assign hit          = hit_q;
   assign hit_addr     = hit_addr_q;
   assign hit_cnt      = hit_cnt_q;
   assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_lookup_engine_tcam.sv
// Bench for lookup_engine_tcam: directed vector table, hand-written pipeline corner sequences,
// and random traffic checked cycle by cycle against a table-level reference model.
module tb_lookup_engine_tcam;
   localparam int PHV_LEN = 1124;
   localparam int KEY_LEN = 197;
   localparam int ACT_LEN = 625;
   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;

   logic               clk;
   logic               rst_n;
   logic [KEY_LEN-1:0] extract_key;
   logic               key_valid;
   logic [PHV_LEN-1:0] phv_in;
   logic [ACT_LEN-1:0] action;
   logic               action_valid;
   logic [PHV_LEN-1:0] phv_out;
   logic               hit;
   logic [ADDR_W-1:0]  hit_addr;
   logic               cfg_wr_en;
   logic [ADDR_W-1:0]  cfg_addr;
   logic [KEY_LEN-1:0] cfg_key;
   logic [KEY_LEN-1:0] cfg_mask;
   logic               cfg_entry_vld;
   logic [ACT_LEN-1:0] cfg_action;
   logic               cfg_dflt_wr;
   logic [31:0]        hit_cnt;
   logic [31:0]        miss_cnt;

   lookup_engine_tcam #(
      .STAGE(0), .PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .ACT_LEN(ACT_LEN),
      .DEPTH(DEPTH), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .extract_key(extract_key), .key_valid(key_valid),
      .phv_in(phv_in), .action(action), .action_valid(action_valid), .phv_out(phv_out),
      .hit(hit), .hit_addr(hit_addr), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
      .cfg_key(cfg_key), .cfg_mask(cfg_mask), .cfg_entry_vld(cfg_entry_vld),
      .cfg_action(cfg_action), .cfg_dflt_wr(cfg_dflt_wr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [ACT_LEN-1:0] act;
      logic [PHV_LEN-1:0] phv;
      logic               hit;
      logic [ADDR_W-1:0]  addr;
   } exp_t;

   typedef struct {
      bit                 is_lk;
      bit                 wr;
      bit                 dw;
      int                 addr;
      logic [KEY_LEN-1:0] key;
      logic [KEY_LEN-1:0] mask;
      bit                 vld;
      logic [ACT_LEN-1:0] act;
      logic [PHV_LEN-1:0] phv;
      bit                 e_hit;
      int                 e_addr;
      logic [ACT_LEN-1:0] e_act;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // reference model: table contents plus in-flight lookups
   logic [KEY_LEN-1:0] m_key [DEPTH];
   logic [KEY_LEN-1:0] m_mask[DEPTH];
   bit                 m_vld [DEPTH];
   logic [ACT_LEN-1:0] m_act [DEPTH];
   logic [ACT_LEN-1:0] m_dflt;
   logic [31:0]        m_hit_cnt, m_miss_cnt;
   bit                 p1_v, p2_v;
   logic [KEY_LEN-1:0] p1_key;
   logic [PHV_LEN-1:0] p1_phv, p2_phv;
   int                 p2_idx;
   exp_t               exp_q[$];
   exp_t               res_q[$];
   exp_t               last;

   task automatic chk(input string name, input logic [PHV_LEN-1:0] got, input logic [PHV_LEN-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (low 128 bits)", name, got[127:0], exp[127:0]);
      end
   endtask

   function automatic int find_match(input logic [KEY_LEN-1:0] k);
      for (int i = 0; i < DEPTH; i++) begin
         if (m_vld[i] && ((k ^ m_key[i]) & m_mask[i]) == '0) return i;
      end
      return -1;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Compare is taken against the table before this edge's write; the action read of a
   // completing lookup likewise sees the table before this edge's write.
   task automatic model_edge();
      exp_t e;
      if (p2_v) begin
         e.hit  = (p2_idx >= 0);
         e.addr = e.hit ? ADDR_W'(p2_idx) : '0;
         e.act  = e.hit ? m_act[p2_idx] : m_dflt;
         e.phv  = p2_phv;
         exp_q.push_back(e);
         if (e.hit) m_hit_cnt = sat_inc(m_hit_cnt);
         else       m_miss_cnt = sat_inc(m_miss_cnt);
      end
      p2_v = p1_v;
      if (p1_v) begin
         p2_idx = find_match(p1_key);
         p2_phv = p1_phv;
      end
      p1_v   = key_valid;
      p1_key = extract_key;
      p1_phv = phv_in;
      if (cfg_wr_en && int'(cfg_addr) < DEPTH) begin
         m_key[cfg_addr]  = cfg_key;
         m_mask[cfg_addr] = cfg_mask;
         m_vld[cfg_addr]  = cfg_entry_vld;
         m_act[cfg_addr]  = cfg_action;
      end
      if (cfg_dflt_wr) m_dflt = cfg_action;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_key[i] = '0; m_mask[i] = '0; m_vld[i] = 1'b0; m_act[i] = '0;
      end
      m_dflt = '0; m_hit_cnt = '0; m_miss_cnt = '0;
      p1_v = 1'b0; p2_v = 1'b0; p2_idx = -1;
      p1_key = '0; p1_phv = '0; p2_phv = '0;
      last = '0;
      exp_q.delete();
   endtask

   // one clock: model the edge, then check every output against the scoreboard
   task automatic step();
      exp_t e;
      exp_t g;
      bit   due;
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      due = (exp_q.size() > 0);
      chk("action_valid", PHV_LEN'(action_valid), PHV_LEN'(due));
      if (due) begin
         e = exp_q.pop_front();
         last = e;
      end
      if (action_valid) begin
         g.act = action; g.phv = phv_out; g.hit = hit; g.addr = hit_addr;
         res_q.push_back(g);
      end
      chk("action", PHV_LEN'(action), PHV_LEN'(last.act));
      chk("phv_out", phv_out, last.phv);
      chk("hit", PHV_LEN'(hit), PHV_LEN'(last.hit));
      chk("hit_addr", PHV_LEN'(hit_addr), PHV_LEN'(last.addr));
      chk("hit_cnt", PHV_LEN'(hit_cnt), PHV_LEN'(m_hit_cnt));
      chk("miss_cnt", PHV_LEN'(miss_cnt), PHV_LEN'(m_miss_cnt));
      key_valid   = 1'b0;
      cfg_wr_en   = 1'b0;
      cfg_dflt_wr = 1'b0;
   endtask

   task automatic wait_res(input int n, output int cnt);
      cnt = 0;
      while (res_q.size() < n && cnt < 12) begin
         step();
         cnt++;
      end
      if (res_q.size() < n) begin
         total++;
         bad++;
         $display("FAIL wait_res got=%0d results exp=%0d", res_q.size(), n);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_clear();
      res_q.delete();
      #1;
      chk("rst action_valid", PHV_LEN'(action_valid), '0);
      chk("rst action", PHV_LEN'(action), '0);
      chk("rst phv_out", phv_out, '0);
      chk("rst hit", PHV_LEN'(hit), '0);
      chk("rst hit_addr", PHV_LEN'(hit_addr), '0);
      chk("rst hit_cnt", PHV_LEN'(hit_cnt), '0);
      chk("rst miss_cnt", PHV_LEN'(miss_cnt), '0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic [KEY_LEN-1:0] k, input logic [PHV_LEN-1:0] p);
      extract_key = k;
      phv_in      = p;
      key_valid   = 1'b1;
      step();
   endtask

   task automatic cfg_write(input int a, input logic [KEY_LEN-1:0] k, input logic [KEY_LEN-1:0] m,
                            input bit v, input logic [ACT_LEN-1:0] act);
      cfg_wr_en     = 1'b1;
      cfg_addr      = ADDR_W'(a);
      cfg_key       = k;
      cfg_mask      = m;
      cfg_entry_vld = v;
      cfg_action    = act;
   endtask

   function automatic logic [PHV_LEN-1:0] rnd_phv();
      logic [PHV_LEN-1:0] r = '0;
      for (int i = 0; i < 36; i++) r = {r[PHV_LEN-33:0], $urandom()};
      return r;
   endfunction

   function automatic logic [ACT_LEN-1:0] rnd_act();
      logic [ACT_LEN-1:0] r = '0;
      for (int i = 0; i < 20; i++) r = {r[ACT_LEN-33:0], $urandom()};
      return r;
   endfunction

   function automatic logic [KEY_LEN-1:0] rnd_key();
      logic [KEY_LEN-1:0] r = '0;
      for (int i = 0; i < 7; i++) r = {r[KEY_LEN-33:0], $urandom()};
      return r;
   endfunction

   function automatic vec_t mk_wr(input int a, input logic [KEY_LEN-1:0] k, input logic [KEY_LEN-1:0] m,
                                  input bit v, input logic [ACT_LEN-1:0] act, input bit wr, input bit dw);
      vec_t t;
      t.is_lk = 1'b0; t.wr = wr; t.dw = dw; t.addr = a; t.key = k; t.mask = m; t.vld = v;
      t.act = act; t.phv = '0; t.e_hit = 1'b0; t.e_addr = 0; t.e_act = '0;
      return t;
   endfunction

   function automatic vec_t mk_lk(input logic [KEY_LEN-1:0] k, input logic [PHV_LEN-1:0] p,
                                  input bit eh, input int ea, input logic [ACT_LEN-1:0] eact);
      vec_t t;
      t.is_lk = 1'b1; t.wr = 1'b0; t.dw = 1'b0; t.addr = 0; t.key = k; t.mask = '0; t.vld = 1'b0;
      t.act = '0; t.phv = p; t.e_hit = eh; t.e_addr = ea; t.e_act = eact;
      return t;
   endfunction

   localparam logic [KEY_LEN-1:0] ONES = '1;
   localparam logic [ACT_LEN-1:0] A2 = 625'hA2A2, A7 = 625'hA7A7, A3 = 625'hA3A3, B7 = 625'hB7B7;
   localparam logic [ACT_LEN-1:0] D55 = 625'h55;

   vec_t vecs[14];

   initial begin
      logic [PHV_LEN-1:0] p0;
      logic [PHV_LEN-1:0] bb_phv[4];
      logic [ACT_LEN-1:0] bb_exp[4];
      logic [31:0]        h0, m0;
      logic [KEY_LEN-1:0] k, m;
      int                 n, nv, r;

      rst_n = 1'b0; extract_key = '0; key_valid = 1'b0; phv_in = '0;
      cfg_wr_en = 1'b0; cfg_addr = '0; cfg_key = '0; cfg_mask = '0;
      cfg_entry_vld = 1'b0; cfg_action = '0; cfg_dflt_wr = 1'b0;

      p0 = '0;
      p0[PHV_LEN-1 -: 48] = '1;
      vecs[0]  = mk_lk(197'h0, p0, 1'b0, 0, '0);
      vecs[1]  = mk_wr(5, 197'h1234, ONES, 1'b1, 625'hABC, 1'b1, 1'b0);
      vecs[2]  = mk_lk(197'h1234, rnd_phv(), 1'b1, 5, 625'hABC);
      vecs[3]  = mk_lk(197'h1235, rnd_phv(), 1'b0, 0, '0);
      vecs[4]  = mk_wr(2, 197'hDEAD, '0, 1'b1, A2, 1'b1, 1'b0);
      vecs[5]  = mk_wr(7, 197'h77, ONES, 1'b1, A7, 1'b1, 1'b0);
      vecs[6]  = mk_lk(197'h77, rnd_phv(), 1'b1, 2, A2);
      vecs[7]  = mk_wr(2, 197'hDEAD, '0, 1'b0, A2, 1'b1, 1'b0);
      vecs[8]  = mk_lk(197'h77, rnd_phv(), 1'b1, 7, A7);
      vecs[9]  = mk_wr(0, '0, '0, 1'b0, D55, 1'b0, 1'b1);
      vecs[10] = mk_lk(197'h1235, rnd_phv(), 1'b0, 0, D55);
      vecs[11] = mk_wr(9, 197'h9, ONES, 1'b1, 625'h99, 1'b1, 1'b1);
      vecs[12] = mk_lk(197'h9, rnd_phv(), 1'b1, 9, 625'h99);
      vecs[13] = mk_lk(197'h8, rnd_phv(), 1'b0, 0, 625'h99);

      do_reset();

      // directed vector table
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].is_lk) begin
            res_q.delete();
            issue(vecs[i].key, vecs[i].phv);
            wait_res(1, n);
            chk($sformatf("v%0d latency", i), PHV_LEN'(n + 1), PHV_LEN'(3));
            if (res_q.size() > 0) begin
               chk($sformatf("v%0d hit", i), PHV_LEN'(res_q[0].hit), PHV_LEN'(vecs[i].e_hit));
               chk($sformatf("v%0d addr", i), PHV_LEN'(res_q[0].addr), PHV_LEN'(vecs[i].e_addr));
               chk($sformatf("v%0d act", i), PHV_LEN'(res_q[0].act), PHV_LEN'(vecs[i].e_act));
               chk($sformatf("v%0d phv", i), res_q[0].phv, vecs[i].phv);
            end
         end else begin
            if (vecs[i].wr)
               cfg_write(vecs[i].addr, vecs[i].key, vecs[i].mask, vecs[i].vld, vecs[i].act);
            cfg_action  = vecs[i].act;
            cfg_dflt_wr = vecs[i].dw;
            step();
         end
      end
      chk("vec hit_cnt", PHV_LEN'(hit_cnt), PHV_LEN'(32'd4));
      chk("vec miss_cnt", PHV_LEN'(miss_cnt), PHV_LEN'(32'd4));

      // back-to-back: miss, hit@7, miss, hit@7 with default 55
      cfg_action = D55; cfg_dflt_wr = 1'b1;
      step();
      h0 = hit_cnt; m0 = miss_cnt;
      res_q.delete();
      nv = 0;
      for (int j = 0; j < 4; j++) begin
         bb_phv[j] = rnd_phv();
         bb_exp[j] = (j % 2 == 1) ? A7 : D55;
         issue((j % 2 == 1) ? 197'h77 : 197'h1235, bb_phv[j]);
         if (action_valid) nv++;
      end
      for (int j = 0; j < 4; j++) begin
         step();
         if (action_valid) nv++;
      end
      chk("b2b valid cycles", PHV_LEN'(nv), PHV_LEN'(4));
      if (res_q.size() == 4) begin
         for (int j = 0; j < 4; j++) begin
            chk($sformatf("b2b act%0d", j), PHV_LEN'(res_q[j].act), PHV_LEN'(bb_exp[j]));
            chk($sformatf("b2b phv%0d", j), res_q[j].phv, bb_phv[j]);
         end
      end
      chk("b2b hit delta", PHV_LEN'(hit_cnt - h0), PHV_LEN'(32'd2));
      chk("b2b miss delta", PHV_LEN'(miss_cnt - m0), PHV_LEN'(32'd2));

      // write to entry 3 during the S2 compare of a lookup only the new entry matches
      res_q.delete();
      issue(197'h333, rnd_phv());
      cfg_write(3, 197'h333, ONES, 1'b1, A3);
      step();
      wait_res(1, n);
      if (res_q.size() > 0) chk("coll first hit", PHV_LEN'(res_q[0].hit), '0);
      res_q.delete();
      issue(197'h333, rnd_phv());
      wait_res(1, n);
      if (res_q.size() > 0) begin
         chk("coll second hit", PHV_LEN'(res_q[0].hit), PHV_LEN'(1'b1));
         chk("coll second addr", PHV_LEN'(res_q[0].addr), PHV_LEN'(3));
      end

      // old entry matches in S2, rewritten action is read in S3
      res_q.delete();
      issue(197'h77, rnd_phv());
      cfg_write(7, 197'h999, ONES, 1'b1, B7);
      step();
      wait_res(1, n);
      if (res_q.size() > 0) begin
         chk("mixed hit", PHV_LEN'(res_q[0].hit), PHV_LEN'(1'b1));
         chk("mixed addr", PHV_LEN'(res_q[0].addr), PHV_LEN'(7));
         chk("mixed act", PHV_LEN'(res_q[0].act), PHV_LEN'(B7));
      end

      // reset one cycle after key_valid
      res_q.delete();
      issue(197'h1234, rnd_phv());
      do_reset();
      repeat (5) step();
      chk("rst no result", PHV_LEN'(res_q.size()), '0);
      issue(197'h1234, rnd_phv());
      wait_res(1, n);
      if (res_q.size() > 0) begin
         chk("post-rst hit", PHV_LEN'(res_q[0].hit), '0);
         chk("post-rst act", PHV_LEN'(res_q[0].act), '0);
      end
      chk("post-rst miss_cnt", PHV_LEN'(miss_cnt), PHV_LEN'(32'd1));

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 9) < 3) begin
            k = KEY_LEN'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            m = (r == 0) ? '0 : (r < 6) ? ONES : (r < 8) ? KEY_LEN'(7) : KEY_LEN'(3);
            cfg_write($urandom_range(0, DEPTH - 1), k, m, $urandom_range(0, 4) != 0, rnd_act());
         end
         if ($urandom_range(0, 9) == 0) begin
            cfg_dflt_wr = 1'b1;
            if (!cfg_wr_en) cfg_action = rnd_act();
         end
         if ($urandom_range(0, 9) < 7) begin
            extract_key = ($urandom_range(0, 4) != 0) ? KEY_LEN'($urandom_range(0, 7)) : rnd_key();
            phv_in      = rnd_phv();
            key_valid   = 1'b1;
         end
         step();
      end
      repeat (5) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
